// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned STRB_W            = XLEN / 8;
  localparam int unsigned LS_STREAK_MAX_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, load/store) onto a single memory port with
// one outstanding transaction, load/store priority and a fetch anti-starvation streak.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LS_STREAK_MAX = LS_STREAK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,

  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned STREAK_W =
    (LS_STREAK_MAX < 1) ? 1 : $clog2(LS_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK_MAX);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                lock_q, lock_d;
  logic                lock_ls_q, lock_ls_d;

  logic                sel_if, sel_ls;
  logic                streak_at_max;

  // State, streak and lock registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      lock_q    <= 1'b0;
      lock_ls_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      lock_q    <= lock_d;
      lock_ls_q <= lock_ls_d;
    end
  end

  assign streak_at_max = (streak_q == STREAK_MAX);

  // Requester selection: a pending lock overrides priority until granted
  always_comb begin
    sel_if = 1'b0;
    sel_ls = 1'b0;
    if (lock_q) begin
      sel_ls = lock_ls_q & ls_req;
      sel_if = ~lock_ls_q & if_req;
    end else begin
      sel_ls = ls_req & ~(if_req & streak_at_max);
      sel_if = if_req & ~sel_ls;
    end
  end

  // Next state, lock, streak and all combinational outputs
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    lock_d    = lock_q;
    lock_ls_d = lock_ls_q;

    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_gnt    = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    if (!rst) begin
      if_rdata = mem_rdata;
      ls_rdata = mem_rdata;

      unique case (state_q)
        IDLE: begin
          if (sel_ls) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_wstrb = ls_wstrb;
            ls_gnt    = mem_gnt;
          end else if (sel_if) begin
            mem_req   = 1'b1;
            mem_addr  = if_addr;
            if_gnt    = mem_gnt;
          end

          // Same-cycle mem_rvalid is never forwarded; response comes from BUSY_x
          if (mem_req && mem_gnt) begin
            state_d = sel_ls ? BUSY_LS : BUSY_IF;
            lock_d  = 1'b0;
          end else if (mem_req) begin
            lock_d    = 1'b1;
            lock_ls_d = sel_ls;
          end else begin
            lock_d    = 1'b0;
          end
        end

        BUSY_IF: begin
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            state_d   = IDLE;
          end
        end

        BUSY_LS: begin
          if (mem_rvalid) begin
            ls_rvalid = 1'b1;
            state_d   = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase

      // Streak counts ls grants made while fetch is waiting
      if (!if_req || if_gnt) begin
        streak_d = '0;
      end else if (ls_gnt && !streak_at_max) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: IDLE-cycle vector table plus multi-cycle sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.LS_STREAK_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_wstrb;
    logic        x_if_gnt;
    logic        x_ls_gnt;
    logic        x_if_rvalid;
    logic        x_ls_rvalid;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [127:0] pack_act();
    return 128'({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                 if_gnt, ls_gnt, if_rvalid, ls_rvalid});
  endfunction

  function automatic logic [127:0] pack_exp(input vec_t v);
    return 128'({v.x_req, v.x_we, v.x_addr, v.x_wdata, v.x_wstrb,
                 v.x_if_gnt, v.x_ls_gnt, v.x_if_rvalid, v.x_ls_rvalid});
  endfunction

  initial begin
    rst = 1'b1;
    clear_inputs();

    // if_req,if_addr,ls_req,ls_we,ls_addr,ls_wdata,ls_wstrb,gnt,rvalid,rdata | req,we,addr,wdata,wstrb,ifg,lsg,ifv,lsv
    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h14,  32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h200, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h104, 32'hA5A5A5A5, 4'hC, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h104, 32'hA5A5A5A5, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h108, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h108, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'hBAD0BAD0,
                1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h30, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFE0000,
                1'b1, 1'b0, 32'h30,  32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'h34, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h34,  32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    check("reset_outputs", pack_act(), 128'h0);
    rst = 1'b0;

    // IDLE-cycle vectors, each from a fresh reset
    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
      ls_req = vecs[i].ls_req;   ls_we = vecs[i].ls_we;     ls_addr = vecs[i].ls_addr;
      ls_wdata = vecs[i].ls_wdata; ls_wstrb = vecs[i].ls_wstrb;
      mem_gnt = vecs[i].mem_gnt; mem_rvalid = vecs[i].mem_rvalid; mem_rdata = vecs[i].mem_rdata;
      #1;
      check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
    end

    // Fetch-only transaction
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("fetch_wait_gnt", 128'({mem_req, mem_addr, if_gnt}), 128'({1'b1, 32'h10, 1'b0}));
    tick();
    mem_gnt = 1'b1;
    #1;
    check("fetch_gnt", 128'({mem_req, mem_addr, if_gnt, ls_gnt}), 128'({1'b1, 32'h10, 1'b1, 1'b0}));
    tick();
    if_req = 1'b0; mem_gnt = 1'b0;
    #1;
    check("fetch_busy_quiet", 128'({mem_req, if_gnt, if_rvalid, ls_rvalid}), 128'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("fetch_rvalid", 128'({if_rvalid, if_rdata, ls_rvalid, ls_gnt}),
          128'({1'b1, 32'hDEADBEEF, 1'b0, 1'b0}));
    tick();
    #1;
    check("fetch_back_idle", 128'({mem_req, if_rvalid, ls_rvalid}), 128'h0);

    // Conflict: ls, ls, then fetch once the streak saturates
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_addr = 32'h200;
    mem_gnt = 1'b1;
    for (int g = 0; g < 3; g++) begin
      #1;
      if (g < 2)
        check($sformatf("conflict_grant%0d", g), 128'({mem_addr, if_gnt, ls_gnt}),
              128'({32'h200, 1'b0, 1'b1}));
      else
        check($sformatf("conflict_grant%0d", g), 128'({mem_addr, if_gnt, ls_gnt}),
              128'({32'h40, 1'b1, 1'b0}));
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(g);
      #1;
      check($sformatf("conflict_resp%0d", g),
            128'({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid}),
            (g < 2) ? 128'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) : 128'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
      tick();
      mem_rvalid = 1'b0;
    end

    // Store: write fields forwarded, ack on ls_rvalid only
    do_reset();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hCAFEF00D; ls_wstrb = 4'h3;
    mem_gnt = 1'b1;
    #1;
    check("store_issue", 128'({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ls_gnt}),
          128'({1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 4'h3, 1'b1}));
    tick();
    ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #1;
    check("store_ack", 128'({ls_rvalid, if_rvalid}), 128'({1'b1, 1'b0}));
    tick();
    mem_rvalid = 1'b0;

    // Lock: fetch held without grant while ls_req rises
    do_reset();
    if_req = 1'b1; if_addr = 32'h80;
    #1;
    check("lock_c0", 128'({mem_req, mem_addr}), 128'({1'b1, 32'h80}));
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'h77; ls_wstrb = 4'hF;
    for (int c = 1; c < 3; c++) begin
      #1;
      check($sformatf("lock_c%0d", c), 128'({mem_addr, mem_we, mem_wstrb, ls_gnt, if_gnt}),
            128'({32'h80, 1'b0, 4'h0, 1'b0, 1'b0}));
      tick();
    end
    mem_gnt = 1'b1;
    #1;
    check("lock_grant", 128'({mem_addr, if_gnt, ls_gnt}), 128'({32'h80, 1'b1, 1'b0}));
    tick();
    clear_inputs();
    mem_rvalid = 1'b1;
    #1;
    check("lock_resp", 128'({if_rvalid, ls_rvalid}), 128'({1'b1, 1'b0}));
    tick();
    mem_rvalid = 1'b0;

    // Reset in BUSY_LS with streak at max: response dropped, streak cleared
    do_reset();
    if_req = 1'b1; if_addr = 32'h50;
    ls_req = 1'b1; ls_addr = 32'h500;
    mem_gnt = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("rst_pre_second_ls", 128'({ls_gnt, if_gnt}), 128'({1'b1, 1'b0}));
    tick();
    rst = 1'b1;
    #1;
    check("rst_outputs_zero", pack_act(), 128'h0);
    tick();
    rst = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    #1;
    check("rst_late_rvalid", 128'({mem_req, ls_rvalid, if_rvalid}), 128'h0);
    tick();
    mem_rvalid = 1'b0;
    if_req = 1'b1; ls_req = 1'b1; mem_gnt = 1'b1;
    #1;
    check("rst_streak_cleared", 128'({mem_req, mem_addr, ls_gnt, if_gnt}),
          128'({1'b1, 32'h500, 1'b1, 1'b0}));
    tick();
    clear_inputs();

    // Stray response in IDLE
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    check("stray_rvalid", 128'({if_rvalid, ls_rvalid, mem_req}), 128'h0);
    tick();
    #1;
    check("stray_rvalid_2", 128'({if_rvalid, ls_rvalid, mem_req}), 128'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
